// File: rtl/line_window_ctrl.sv
// Line-buffer controller feeding the 3x3 Sobel/convolution MAC.
// Stores a raster pixel stream in four rotating line buffers. Once three full lines are held,
// it emits one line of 3x3 windows, frees the oldest buffer and pulses o_intr.
module line_window_ctrl #(
  parameter int unsigned IMG_WIDTH = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_pixel_data,
  input  logic        i_pixel_data_valid,
  input  logic        i_proc_en,
  output logic [71:0] o_pixel_data,
  output logic        o_pixel_data_valid,
  output logic        o_intr,
  output logic        o_overflow
);

  localparam int unsigned PtrW = $clog2(IMG_WIDTH);
  localparam int unsigned SumW = PtrW + 1;
  localparam int unsigned CntW = $clog2(4 * IMG_WIDTH) + 1;

  localparam logic [PtrW-1:0] LastCol    = PtrW'(IMG_WIDTH - 1);
  localparam logic [CntW-1:0] FillThresh = CntW'(3 * IMG_WIDTH);
  localparam logic [CntW-1:0] FullCount  = CntW'(4 * IMG_WIDTH);

  typedef enum logic {
    StIdle = 1'b0,
    StRd   = 1'b1
  } state_e;

  state_e r_state;
  state_e w_state_next;

  // Line store; contents deliberately survive reset.
  logic [7:0] r_line_buf [4][IMG_WIDTH];

  logic [PtrW-1:0] r_wr_ptr;
  logic [1:0]      r_wr_buf;
  logic [PtrW-1:0] r_rd_ptr;
  logic [1:0]      r_rd_buf;
  logic [CntW-1:0] r_total_pixel;

  logic [71:0] r_pixel_data;
  logic        r_pixel_data_valid;
  logic        r_intr;
  logic        r_overflow;

  logic            w_wr_accept;
  logic            w_wr_drop;
  logic            w_rd_en;
  logic [1:0]      w_row_sel [3];
  logic [SumW-1:0] w_col_sum [3];
  logic [PtrW-1:0] w_col_sel [3];
  logic [71:0]     w_window;

  assign w_wr_accept = i_pixel_data_valid && (r_total_pixel < FullCount);
  assign w_wr_drop   = i_pixel_data_valid && (r_total_pixel == FullCount);
  assign w_rd_en     = (r_state == StRd);

  // Store accepted pixels into the current write buffer.
  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_line_buf[r_wr_buf][r_wr_ptr] <= i_pixel_data;
    end
  end

  // Advance the write pointer; wrap to the next buffer at end of line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_wr_buf <= '0;
    end else if (w_wr_accept) begin
      if (r_wr_ptr == LastCol) begin
        r_wr_ptr <= '0;
        r_wr_buf <= r_wr_buf + 2'd1;
      end else begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
    end
  end

  // Sticky flag: a pixel arrived while all four buffers were full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_wr_drop) begin
      r_overflow <= 1'b1;
    end
  end

  // Occupancy: +1 per accepted write, -1 per read cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_total_pixel <= '0;
    end else begin
      unique case ({w_wr_accept, w_rd_en})
        2'b10:   r_total_pixel <= r_total_pixel + CntW'(1);
        2'b01:   r_total_pixel <= r_total_pixel - CntW'(1);
        default: r_total_pixel <= r_total_pixel;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: start a line once three are buffered, stop after its last column.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if ((r_total_pixel >= FillThresh) && i_proc_en) begin
          w_state_next = StRd;
        end
      end
      StRd: begin
        if (r_rd_ptr == LastCol) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Row buffers and right-edge-clamped columns for the current window.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_row_sel[r] = r_rd_buf + 2'(r);
    end
    for (int c = 0; c < 3; c++) begin
      w_col_sum[c] = {1'b0, r_rd_ptr} + SumW'(c);
      w_col_sel[c] = (w_col_sum[c] > {1'b0, LastCol}) ? LastCol : w_col_sum[c][PtrW-1:0];
    end
  end

  // Assemble the 3x3 window, byte 3*row+col, top-left in the low byte.
  always_comb begin
    w_window = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w_window[(3*r+c)*8 +: 8] = r_line_buf[w_row_sel[r]][w_col_sel[c]];
      end
    end
  end

  // Read side: register windows, step the read pointer, rotate buffers at end of line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr           <= '0;
      r_rd_buf           <= '0;
      r_pixel_data       <= '0;
      r_pixel_data_valid <= 1'b0;
      r_intr             <= 1'b0;
    end else begin
      r_pixel_data_valid <= w_rd_en;
      r_intr             <= 1'b0;
      if (w_rd_en) begin
        r_pixel_data <= w_window;
        if (r_rd_ptr == LastCol) begin
          r_rd_ptr <= '0;
          r_rd_buf <= r_rd_buf + 2'd1;
          r_intr   <= 1'b1;
        end else begin
          r_rd_ptr <= r_rd_ptr + PtrW'(1);
        end
      end
    end
  end

  assign o_pixel_data       = r_pixel_data;
  assign o_pixel_data_valid = r_pixel_data_valid;
  assign o_intr             = r_intr;
  assign o_overflow         = r_overflow;

endmodule

// File: tb/tb_line_window_ctrl.sv
// Self-checking bench for line_window_ctrl with IMG_WIDTH=8 and pixel value 16*line+col.
// Expected windows are queued as each line completes and popped as windows appear.
module tb_line_window_ctrl;

  localparam int W = 8;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RD   = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_pixel_data;
  logic        i_pixel_data_valid;
  logic        i_proc_en;
  logic [71:0] o_pixel_data;
  logic        o_pixel_data_valid;
  logic        o_intr;
  logic        o_overflow;

  always #5 clk = ~clk;

  line_window_ctrl #(
    .IMG_WIDTH(W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_pixel_data      (i_pixel_data),
    .i_pixel_data_valid(i_pixel_data_valid),
    .i_proc_en         (i_proc_en),
    .o_pixel_data      (o_pixel_data),
    .o_pixel_data_valid(o_pixel_data_valid),
    .o_intr            (o_intr),
    .o_overflow        (o_overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [71:0] exp_q [$];
  int win_total   = 0;
  int intr_total  = 0;
  int win_in_line = 0;
  int tb_line     = 0;
  int tb_col      = 0;

  task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] exp_window(input int line, input int col);
    logic [71:0] w;
    int cc;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        cc = col + k;
        if (cc > W - 1) cc = W - 1;
        w[(3*r+k)*8 +: 8] = 8'(16 * (line + r) + cc);
      end
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the next raster pixel for one cycle; queue windows once a line completes a triple.
  task automatic send_px();
    i_pixel_data       = 8'(16 * tb_line + tb_col);
    i_pixel_data_valid = 1'b1;
    tick();
    if (tb_col == W - 1) begin
      if (tb_line >= 2) begin
        for (int c = 0; c < W; c++) exp_q.push_back(exp_window(tb_line - 2, c));
      end
      tb_col = 0;
      tb_line++;
    end else begin
      tb_col++;
    end
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    i_pixel_data_valid = 1'b0;
    tick();
    tick();
    rst     = 1'b0;
    tb_line = 0;
    tb_col  = 0;
  endtask

  // Fill to threshold from empty and read the first line, checking latency and edge windows.
  task automatic scen_fill();
    repeat (23) send_px();
    i_pixel_data_valid = 1'b0;
    tick();
    tick();
    check_eq("fill_no_valid", 72'(o_pixel_data_valid), 72'(0));
    check_eq("fill_total23", 72'(dut.r_total_pixel), 72'(23));
    send_px();
    i_pixel_data_valid = 1'b0;
    check_eq("lat_n_valid", 72'(o_pixel_data_valid), 72'(0));
    tick();
    check_eq("lat_n1_valid", 72'(o_pixel_data_valid), 72'(0));
    check_eq("lat_n1_state", 72'(dut.r_state), 72'(ST_RD));
    tick();
    for (int i = 0; i < W; i++) begin
      check_eq("line_contig", 72'(o_pixel_data_valid), 72'(1));
      check_eq("line_intr", 72'(o_intr), 72'(i == W - 1));
      if (i == 0) check_eq("win_col0", o_pixel_data,
        {8'd34, 8'd33, 8'd32, 8'd18, 8'd17, 8'd16, 8'd2, 8'd1, 8'd0});
      if (i == 6) check_eq("win_col6", o_pixel_data,
        {8'd39, 8'd39, 8'd38, 8'd23, 8'd23, 8'd22, 8'd7, 8'd7, 8'd6});
      if (i == 7) check_eq("win_col7", o_pixel_data,
        {8'd39, 8'd39, 8'd39, 8'd23, 8'd23, 8'd23, 8'd7, 8'd7, 8'd7});
      tick();
    end
    check_eq("line_end_valid", 72'(o_pixel_data_valid), 72'(0));
    check_eq("line_end_intr", 72'(o_intr), 72'(0));
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      win_in_line = 0;
    end else begin
      if (o_pixel_data_valid) begin
        if (exp_q.size() == 0) check_eq("unexpected_valid", 72'(o_pixel_data_valid), 72'(0));
        else check_eq("window", o_pixel_data, exp_q.pop_front());
        check_eq("intr_on_last", 72'(o_intr), 72'(win_in_line == W - 1));
        win_in_line = (win_in_line + 1) % W;
        win_total++;
      end else if (o_intr) begin
        check_eq("intr_without_valid", 72'(o_intr), 72'(0));
      end
      if (o_intr) intr_total++;
    end
  end

  initial begin
    int w0;
    int i0;
    int k;
    rst                = 1'b1;
    i_pixel_data       = '0;
    i_pixel_data_valid = 1'b0;
    i_proc_en          = 1'b1;
    tick();
    tick();
    check_eq("rst_data", o_pixel_data, 72'(0));
    check_eq("rst_valid", 72'(o_pixel_data_valid), 72'(0));
    check_eq("rst_intr", 72'(o_intr), 72'(0));
    check_eq("rst_ovf", 72'(o_overflow), 72'(0));
    check_eq("rst_total", 72'(dut.r_total_pixel), 72'(0));
    check_eq("rst_state", 72'(dut.r_state), 72'(ST_IDLE));
    rst = 1'b0;

    // Threshold, latency and right-edge clamp.
    scen_fill();

    // Continuous six-line stream: rotation, idle gap, constant occupancy during reads.
    do_reset();
    w0 = win_total;
    i0 = intr_total;
    for (int p = 0; p < 6 * W; p++) begin
      send_px();
      if (p >= 24 && p <= 32) check_eq("tot_const", 72'(dut.r_total_pixel), 72'(25));
      if (p == 33) check_eq("idle_gap", 72'(o_pixel_data_valid), 72'(0));
      if (p == 34) begin
        check_eq("rot_valid", 72'(o_pixel_data_valid), 72'(1));
        check_eq("rot_first", o_pixel_data,
          {8'd50, 8'd49, 8'd48, 8'd34, 8'd33, 8'd32, 8'd18, 8'd17, 8'd16});
      end
    end
    i_pixel_data_valid = 1'b0;
    repeat (60) tick();
    check_eq("stream_windows", 72'(win_total - w0), 72'(4 * W));
    check_eq("stream_intr", 72'(intr_total - i0), 72'(4));
    check_eq("stream_sb_empty", 72'(exp_q.size()), 72'(0));
    check_eq("stream_total", 72'(dut.r_total_pixel), 72'(16));

    // Overflow: fill all four buffers with reads held off, then drop one pixel.
    do_reset();
    i_proc_en = 1'b0;
    repeat (4 * W) send_px();
    i_pixel_data_valid = 1'b0;
    tick();
    check_eq("pre_ovf", 72'(o_overflow), 72'(0));
    check_eq("full_total", 72'(dut.r_total_pixel), 72'(32));
    check_eq("full_no_valid", 72'(o_pixel_data_valid), 72'(0));
    i_pixel_data       = 8'(16 * 4);
    i_pixel_data_valid = 1'b1;
    tick();
    i_pixel_data_valid = 1'b0;
    check_eq("ovf_set", 72'(o_overflow), 72'(1));
    check_eq("ovf_total", 72'(dut.r_total_pixel), 72'(32));
    check_eq("ovf_wr_ptr", 72'(dut.r_wr_ptr), 72'(0));
    check_eq("ovf_wr_buf", 72'(dut.r_wr_buf), 72'(0));
    w0 = win_total;
    i_proc_en = 1'b1;
    repeat (30) tick();
    check_eq("ovf_windows", 72'(win_total - w0), 72'(2 * W));
    check_eq("ovf_sticky", 72'(o_overflow), 72'(1));
    check_eq("ovf_drain_total", 72'(dut.r_total_pixel), 72'(16));

    // Reset in the middle of a line read.
    repeat (W) send_px();
    i_pixel_data_valid = 1'b0;
    k = 0;
    while (!(dut.r_state == ST_RD && dut.r_rd_ptr == 3'd4) && k < 50) begin
      tick();
      k++;
    end
    check_eq("midrst_reach", 72'(k < 50), 72'(1));
    rst = 1'b1;
    tick();
    check_eq("midrst_data", o_pixel_data, 72'(0));
    check_eq("midrst_valid", 72'(o_pixel_data_valid), 72'(0));
    check_eq("midrst_intr", 72'(o_intr), 72'(0));
    check_eq("midrst_ovf", 72'(o_overflow), 72'(0));
    check_eq("midrst_state", 72'(dut.r_state), 72'(ST_IDLE));
    check_eq("midrst_total", 72'(dut.r_total_pixel), 72'(0));
    check_eq("midrst_rd_ptr", 72'(dut.r_rd_ptr), 72'(0));
    check_eq("midrst_wr_ptr", 72'(dut.r_wr_ptr), 72'(0));
    rst     = 1'b0;
    tb_line = 0;
    tb_col  = 0;
    scen_fill();
    repeat (4) tick();
    check_eq("final_sb_empty", 72'(exp_q.size()), 72'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_window_ctrl.md
Name: line_window_ctrl

Overview:
- Controller and line store that sequences the 3x3 Sobel/convolution MAC.
- Accepts a raster stream of 8-bit pixels and stores it in four rotating line buffers, each IMG_WIDTH wide.
- Once three full lines are buffered, it reads one line of 72-bit 3x3 windows, then rotates the buffers.
- Raises a one-cycle interrupt per consumed line so the upstream DMA can send the next line.

Parameters:
- IMG_WIDTH, 512, pixels per line (>=4); the line-pointer width is clog2(IMG_WIDTH).
- Fill threshold: fixed at 3*IMG_WIDTH stored pixels.

Ports:
- clk  input  1  sole clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- i_pixel_data  input  8  incoming pixel, raster order.
- i_pixel_data_valid  input  1  i_pixel_data is valid this cycle.
- i_proc_en  input  1  permits starting a new line read.
- o_pixel_data  output  72  3x3 window; [7:0]=top-left, row-major, [71:64]=bottom-right.
- o_pixel_data_valid  output  1  o_pixel_data is valid.
- o_intr  output  1  one-cycle pulse, one line buffer freed.
- o_overflow  output  1  sticky; a write was dropped.

Behaviour:
- Reset: the following all go to 0:
  - o_pixel_data, o_pixel_data_valid, o_intr, o_overflow
  - wr_ptr, wr_buf, rd_ptr, rd_buf, total_pixel
  - FSM goes to IDLE.
  - Buffer RAM contents are not cleared.
  - Reset mid-line discards all partial state; the next pixel is treated as col 0 of line 0.
- Write side:
  - When valid and total_pixel < 4*IMG_WIDTH: buf[wr_buf][wr_ptr] <= pixel and wr_ptr++.
  - At wr_ptr==IMG_WIDTH-1: wr_ptr wraps to 0 and wr_buf increments mod 4.
- Overflow:
  - When valid and total_pixel == 4*IMG_WIDTH, the pixel is dropped.
  - The drop changes no pointers and sets o_overflow=1 until reset.
- total_pixel counter:
  - Range 0..4*IMG_WIDTH, width clog2(4*IMG_WIDTH)+1.
  - +1 per accepted write, -1 per read cycle; an accepted write and a read in the same cycle leave it unchanged.
- FSM states and transitions:
  - IDLE -> RD when total_pixel >= 3*IMG_WIDTH and i_proc_en=1 (registered values).
  - In RD: rd_en=1 (combinational, state==RD); rd_ptr++ every cycle.
  - RD -> IDLE at the edge where rd_ptr==IMG_WIDTH-1. On that edge: rd_ptr<=0, rd_buf<=rd_buf+1 mod 4, o_intr<=1 for exactly one cycle.
  - i_proc_en deasserting during RD does not abort the line.
  - At least one IDLE cycle separates consecutive lines.
- Window formation:
  - Rows: top=buf[rd_buf], mid=buf[rd_buf+1], bot=buf[rd_buf+2], all mod 4.
  - Columns: rd_ptr, rd_ptr+1, rd_ptr+2, each clamped to IMG_WIDTH-1 (right-edge replication).
  - Byte k=3*row+col.
- Latency and ordering:
  - Window and valid are registered on the rd_en cycle's edge.
  - Each line produces exactly IMG_WIDTH contiguous valid windows.
  - If the pixel completing the threshold is sampled at edge N: state=RD after N+1, first valid after N+2.
  - o_intr rises on the same edge as the last valid window of the line.
- Write/read hazard: accepted writes never land on a column still to be read, because total_pixel gating guarantees the writer trails the reader in the recycled buffer. No extra interlock is needed.
- Outputs hold their last values when not valid; only the valid qualifies o_pixel_data.

Test Plan:
(IMG_WIDTH=8; pixel value = 16*line + col; i_proc_en=1 unless stated.)
1. Fill threshold:
   - Stimulus: after reset, stream 23 pixels.
   - Required: valid stays 0, total_pixel=23.
   - Stimulus: 24th pixel at edge N.
   - Required: first valid after edge N+2 with window {34,33,32,18,17,16,2,1,0}; 8 contiguous valid windows follow.
2. Edge clamp:
   - Window col 6 = {39,39,38,23,23,22,7,7,6}.
   - Window col 7 = {39,39,39,23,23,23,7,7,7}.
   - o_intr high exactly once, coincident with col-7 valid.
3. Rotation:
   - Stimulus: send line 3 (48..55) before the first line read ends.
   - Required: after one IDLE cycle, the second read produces first window {50,49,48,34,33,32,18,17,16}; a second o_intr pulse follows.
   - Continuous 6-line stream -> exactly 4 lines of windows and 4 o_intr pulses.
4. Overflow:
   - Stimulus: i_proc_en=0, write 33 pixels.
   - Required: pixel 33 dropped, total_pixel=32, o_overflow=1.
   - Stimulus: raise i_proc_en.
   - Required: reads proceed with line-0 data intact; o_overflow stays 1 until rst.
5. Simultaneous read/write:
   - Stimulus: one write every cycle during RD.
   - Required: total_pixel constant across the line.
6. Reset mid-operation:
   - Stimulus: assert rst at rd_ptr=4.
   - Required: next cycle all outputs 0 and FSM IDLE; refilling 24 pixels reproduces scenario 1 exactly.
